// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default address width and gray/binary helpers.
// Callers zero-extend into FUNC_WIDTH bits and slice the result back to pointer width.
package fifo_pkg;

    localparam int ADDRESS_SIZE = 3;
    localparam int FUNC_WIDTH   = 32;

    function automatic logic [FUNC_WIDTH-1:0] bin2gray(input logic [FUNC_WIDTH-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all gray bits at and above it.
    function automatic logic [FUNC_WIDTH-1:0] gray2bin(input logic [FUNC_WIDTH-1:0] gray);
        logic [FUNC_WIDTH-1:0] bin;
        bin[FUNC_WIDTH-1] = gray[FUNC_WIDTH-1];
        for (int i = FUNC_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/pointer_sync.sv
// Multi-flop synchroniser for a gray-coded pointer crossing clock domains.
// Used for the write pointer here and for the read pointer on the write side.
module pointer_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Pure flop chain: any logic between stages would defeat metastability settling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/rdpt_empty_sync.sv
// Read-side pointer and empty/occupancy controller of the dual-clock FIFO.
// Status is computed from the next pointer so flags are registered yet current after a pop.
module rdpt_empty_sync
    import fifo_pkg::*;
#(
    parameter int address_size       = ADDRESS_SIZE,
    parameter int sync_stages        = 2,
    parameter int almost_empty_level = 1
) (
    input  logic                    read_clk_i,
    input  logic                    read_reset_i,
    input  logic [address_size:0]   write_pointer_i,
    input  logic                    read_increment_i,
    input  logic                    read_underflow_clear_i,
    output logic [address_size-1:0] read_address_o,
    output logic [address_size:0]   read_pointer_o,
    output logic                    read_empty_o,
    output logic                    read_almost_empty_o,
    output logic [address_size:0]   read_level_o,
    output logic                    read_underflow_o
);

    localparam int PW = address_size + 1;

    logic [PW-1:0] binary_q, binary_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] wsync_gray, wsync_bin;
    logic          empty_q, empty_d;
    logic          almost_q, almost_d;
    logic          underflow_q, underflow_d;
    logic          pop_ok;

    pointer_sync #(
        .WIDTH  (PW),
        .STAGES (sync_stages)
    ) u_wptr_sync (
        .clk_i (read_clk_i),
        .rst_i (read_reset_i),
        .d_i   (write_pointer_i),
        .q_o   (wsync_gray)
    );

    // The synchronised write pointer can only lag, so level and empty err on the safe side.
    always_comb begin
        pop_ok      = read_increment_i & ~empty_q;
        binary_d    = binary_q + PW'(pop_ok);
        gray_d      = PW'(bin2gray(FUNC_WIDTH'(binary_d)));
        wsync_bin   = PW'(gray2bin(FUNC_WIDTH'(wsync_gray)));
        level_d     = wsync_bin - binary_d;
        empty_d     = (gray_d == wsync_gray);
        almost_d    = (level_d <= PW'(almost_empty_level));
        underflow_d = (read_increment_i & empty_q) | (underflow_q & ~read_underflow_clear_i);
    end

    always_ff @(posedge read_clk_i) begin
        if (read_reset_i) begin
            binary_q    <= '0;
            gray_q      <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            almost_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            binary_q    <= binary_d;
            gray_q      <= gray_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            almost_q    <= almost_d;
            underflow_q <= underflow_d;
        end
    end

    assign read_address_o      = binary_q[address_size-1:0];
    assign read_pointer_o      = gray_q;
    assign read_empty_o        = empty_q;
    assign read_almost_empty_o = almost_q;
    assign read_level_o        = level_q;
    assign read_underflow_o    = underflow_q;

endmodule

// File: tb/tb_rdpt_empty_sync.sv
// Self-checking bench for rdpt_empty_sync: directed literal checks plus a
// cycle-by-cycle comparison against an arithmetic occupancy model under random traffic.
module tb_rdpt_empty_sync;

    localparam int A     = 3;
    localparam int S     = 2;
    localparam int AEL   = 1;
    localparam int PW    = A + 1;
    localparam int MOD   = 1 << PW;
    localparam int DEPTH = 1 << A;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] wp;
    logic          inc;
    logic          clr;
    logic [A-1:0]  addr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          almost;
    logic [PW-1:0] level;
    logic          uflow;

    int testsRun    = 0;
    int testsFailed = 0;

    rdpt_empty_sync #(
        .address_size       (A),
        .sync_stages        (S),
        .almost_empty_level (AEL)
    ) dut (
        .read_clk_i             (clk),
        .read_reset_i           (rst),
        .write_pointer_i        (wp),
        .read_increment_i       (inc),
        .read_underflow_clear_i (clr),
        .read_address_o         (addr),
        .read_pointer_o         (rptr),
        .read_empty_o           (empty),
        .read_almost_empty_o    (almost),
        .read_level_o           (level),
        .read_underflow_o       (uflow)
    );

    always #5 clk = ~clk;

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & (MOD - 1);
    endfunction

    function automatic int g2b(input int g);
        int b;
        b = g;
        for (int s = 1; s < PW; s++) b = b ^ (g >> s);
        return b & (MOD - 1);
    endfunction

    // Model: reads pointer count, the write pointer seen S edges late, and occupancy by subtraction.
    int  mRd;
    int  mLvl;
    bit  mEmpty;
    bit  mAlmost;
    bit  mUf;
    bit  modelValid = 0;
    int  wq[$];
    int  obs;
    bit  popOk;
    bit  under;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            mRd = 0; mLvl = 0; mEmpty = 1; mAlmost = 1; mUf = 0;
            wq.delete();
            for (int i = 0; i < S; i++) wq.push_back(0);
            modelValid = 1;
        end else if (modelValid) begin
            obs     = wq[0];
            popOk   = inc && !mEmpty;
            under   = inc && mEmpty;
            mRd     = (mRd + int'(popOk)) % MOD;
            mLvl    = (g2b(obs) - mRd + MOD) % MOD;
            mEmpty  = (mLvl == 0);
            mAlmost = (mLvl <= AEL);
            mUf     = under || (mUf && !clr);
            void'(wq.pop_front());
            wq.push_back(int'(wp));
        end
    end

    logic [13:0] expVec;
    logic [13:0] actVec;

    always @(negedge clk) begin
        if (modelValid) begin
            expVec = {4'(b2g(mRd)), 3'(mRd % DEPTH), mEmpty, mAlmost, 4'(mLvl), mUf};
            actVec = {rptr, addr, empty, almost, level, uflow};
            testsRun++;
            if (actVec !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL model_compare t=%0t: got ptr=%b addr=%0d empty=%b almost=%b level=%0d uf=%b, expected ptr=%b addr=%0d empty=%b almost=%b level=%0d uf=%b",
                         $time, rptr, addr, empty, almost, level, uflow,
                         expVec[13:10], expVec[9:7], expVec[6], expVec[5], expVec[4:1], expVec[0]);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [PW-1:0] w, input logic i, input logic c);
        rst = r; wp = w; inc = i; clr = c;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    int wrBin;
    int expPtr[4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("reset_empty", int'(empty), 1);
        checkOutput("reset_almost", int'(almost), 1);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_ptr", int'(rptr), 0);
        checkOutput("reset_addr", int'(addr), 0);
        checkOutput("reset_uf", int'(uflow), 0);

        // Synchroniser latency
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
        checkOutput("sync_not_early", int'(empty), 1);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
        checkOutput("sync_empty_fall", int'(empty), 0);
        checkOutput("sync_level1", int'(level), 1);
        checkOutput("sync_almost1", int'(almost), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0);
        checkOutput("sync_level3", int'(level), 3);
        checkOutput("sync_almost3", int'(almost), 0);

        // Drain four words
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0);
        checkOutput("drain_level4", int'(level), 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("drain_addr%0d", k), int'(addr), k);
            applyStimulus(1'b0, 4'b0110, 1'b1, 1'b0);
            checkOutput($sformatf("drain_ptr%0d", k), int'(rptr), expPtr[k]);
            checkOutput($sformatf("drain_level%0d", k), int'(level), 3 - k);
            checkOutput($sformatf("drain_almost%0d", k), int'(almost), (3 - k) <= AEL ? 1 : 0);
        end
        checkOutput("drain_empty", int'(empty), 1);

        // Underflow: set, set-beats-clear, clear
        applyStimulus(1'b0, 4'b0110, 1'b1, 1'b0);
        checkOutput("uf_ptr_hold", int'(rptr), 4'b0110);
        checkOutput("uf_set", int'(uflow), 1);
        applyStimulus(1'b0, 4'b0110, 1'b1, 1'b1);
        checkOutput("uf_set_wins", int'(uflow), 1);
        applyStimulus(1'b0, 4'b0110, 1'b0, 1'b1);
        checkOutput("uf_clear", int'(uflow), 0);

        // Full and wrap
        applyStimulus(1'b1, 4'b1100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1100, 1'b0, 1'b0);
        checkOutput("full_level8", int'(level), 8);
        checkOutput("full_not_empty", int'(empty), 0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b1100, 1'b1, 1'b0);
        checkOutput("wrap_ptr", int'(rptr), 4'b1100);
        checkOutput("wrap_empty", int'(empty), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
        checkOutput("wrap_level1", int'(level), 1);
        checkOutput("wrap_addr0", int'(addr), 0);

        // Reset during a pop burst
        applyStimulus(1'b1, 4'b0111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0);
        checkOutput("mid_level5", int'(level), 5);
        applyStimulus(1'b1, 4'b0111, 1'b1, 1'b0);
        checkOutput("mid_rst_level", int'(level), 0);
        checkOutput("mid_rst_empty", int'(empty), 1);
        checkOutput("mid_rst_ptr", int'(rptr), 0);
        applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0);
        checkOutput("mid_not_early", int'(level), 0);
        applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0);
        checkOutput("mid_recover5", int'(level), 5);

        // Random traffic against the model
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        wrBin = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                wrBin = 0;
                applyStimulus(1'b1, 4'b0000, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                if ($urandom_range(0, 1) == 1 && ((wrBin - mRd + MOD) % MOD) < DEPTH)
                    wrBin = (wrBin + 1) % MOD;
                applyStimulus(1'b0, 4'(b2g(wrBin)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 7) == 0));
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
